// File: rtl/cpu_trace_ctrl.sv
// Run controller and trace capture for the single-cycle RISC-V core.
// Gates the core PC enable, records one entry per enabled cycle into a ring buffer, drains it oldest-first.
module cpu_trace_ctrl #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 16,
    parameter int CYCLE_W = 16,
    parameter int PT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop_req,
    input  logic [CYCLE_W-1:0] max_cycles,
    input  logic               trig_en,
    input  logic [XLEN-1:0]    trig_pc,
    input  logic [PT_W-1:0]    post_trig,
    input  logic [XLEN-1:0]    cpu_pc,
    input  logic [XLEN-1:0]    cpu_aluout,
    input  logic               cpu_memread,
    input  logic               cpu_memwrite,
    output logic               pc_en,
    output logic               running,
    output logic               done,
    output logic               triggered,
    output logic               wrapped,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [XLEN-1:0]    rd_pc,
    output logic [XLEN-1:0]    rd_aluout,
    output logic [1:0]         rd_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_POST,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu;
        logic            memread;
        logic            memwrite;
    } entry_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               wrapped_q, wrapped_d;
    logic               triggered_q, triggered_d;
    logic               pc_en_q, pc_en_d;
    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic [PT_W-1:0]    post_q, post_d;

    entry_t             mem [DEPTH];

    logic               capture;
    logic [CYCLE_W-1:0] cycle_inc;
    logic               end_hit;
    logic               trig_hit;
    logic               pop;
    entry_t             rd_entry;

    always_comb begin
        capture   = (state_q == S_RUN) || (state_q == S_POST);
        cycle_inc = (cycle_q == '1) ? cycle_q : cycle_q + CYCLE_W'(1);
        // Budget compares against the count including the capture happening on this edge.
        end_hit   = stop_req
                 || ((max_cycles != '0) && (cycle_inc == max_cycles))
                 || ((state_q == S_POST) && (post_q == PT_W'(1)));
        trig_hit  = (state_q == S_RUN) && trig_en && (cpu_pc == trig_pc);
        rd_valid  = (state_q == S_DONE) && (count_q != '0);
        pop       = rd_valid && rd_ready;
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wrapped_d   = wrapped_q;
        triggered_d = triggered_q;
        cycle_d     = cycle_q;
        post_d      = post_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RUN;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    count_d     = '0;
                    wrapped_d   = 1'b0;
                    triggered_d = 1'b0;
                    cycle_d     = '0;
                    post_d      = '0;
                end else if (pop) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    count_d  = count_q - CW'(1);
                end
            end
            default: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                cycle_d  = cycle_inc;
                if (count_q == CW'(DEPTH)) begin
                    rd_ptr_d  = rd_ptr_q + AW'(1);
                    wrapped_d = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
                if (state_q == S_POST) begin
                    post_d = post_q - PT_W'(1);
                end

                if (end_hit) begin
                    state_d = S_DONE;
                end else if (trig_hit) begin
                    triggered_d = 1'b1;
                    post_d      = post_trig;
                    state_d     = (post_trig == '0) ? S_DONE : S_POST;
                end
            end
        endcase

        pc_en_d = (state_d == S_RUN) || (state_d == S_POST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wrapped_q   <= 1'b0;
            triggered_q <= 1'b0;
            pc_en_q     <= 1'b0;
            cycle_q     <= '0;
            post_q      <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wrapped_q   <= wrapped_d;
            triggered_q <= triggered_d;
            pc_en_q     <= pc_en_d;
            cycle_q     <= cycle_d;
            post_q      <= post_d;
        end
    end

    // NOTE: trace storage is not reset; count_q alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            mem[wr_ptr_q] <= '{pc: cpu_pc, alu: cpu_aluout, memread: cpu_memread, memwrite: cpu_memwrite};
        end
    end

    assign rd_entry    = mem[rd_ptr_q];
    assign rd_pc       = rd_valid ? rd_entry.pc  : '0;
    assign rd_aluout   = rd_valid ? rd_entry.alu : '0;
    assign rd_flags    = rd_valid ? {rd_entry.memread, rd_entry.memwrite} : 2'b00;

    assign pc_en       = pc_en_q;
    assign running     = (state_q == S_RUN) || (state_q == S_POST);
    assign done        = (state_q == S_DONE);
    assign triggered   = triggered_q;
    assign wrapped     = wrapped_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_cpu_trace_ctrl.sv
// Randomized scoreboard bench for cpu_trace_ctrl: a run-level model predicts capture count and
// buffer contents; a negedge monitor compares every presented trace entry against the queue.
module tb_cpu_trace_ctrl;

    localparam int XLEN    = 32;
    localparam int DEPTH   = 16;
    localparam int CYCLE_W = 16;
    localparam int PT_W    = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [1:0]  fl;
    } ent_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               stop_req;
    logic [CYCLE_W-1:0] max_cycles;
    logic               trig_en;
    logic [XLEN-1:0]    trig_pc;
    logic [PT_W-1:0]    post_trig;
    logic [XLEN-1:0]    cpu_pc;
    logic [XLEN-1:0]    cpu_aluout;
    logic               cpu_memread;
    logic               cpu_memwrite;
    logic               pc_en;
    logic               running;
    logic               done;
    logic               triggered;
    logic               wrapped;
    logic [CYCLE_W-1:0] cycle_count;
    logic               rd_valid;
    logic               rd_ready;
    logic [XLEN-1:0]    rd_pc;
    logic [XLEN-1:0]    rd_aluout;
    logic [1:0]         rd_flags;

    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    ent_t exp_q[$];

    logic [31:0] s_pc  [1:64];
    logic [31:0] s_alu [1:64];
    logic [1:0]  s_fl  [1:64];

    cpu_trace_ctrl #(
        .XLEN(XLEN), .DEPTH(DEPTH), .CYCLE_W(CYCLE_W), .PT_W(PT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop_req(stop_req),
        .max_cycles(max_cycles), .trig_en(trig_en), .trig_pc(trig_pc), .post_trig(post_trig),
        .cpu_pc(cpu_pc), .cpu_aluout(cpu_aluout), .cpu_memread(cpu_memread),
        .cpu_memwrite(cpu_memwrite), .pc_en(pc_en), .running(running), .done(done),
        .triggered(triggered), .wrapped(wrapped), .cycle_count(cycle_count),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_aluout(rd_aluout),
        .rd_flags(rd_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares whatever the DUT presents against the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en && rd_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_entry", rd_valid, 1'b0);
            end else begin
                check("rd_pc", rd_pc, exp_q[0].pc);
                check("rd_aluout", rd_aluout, exp_q[0].alu);
                check("rd_flags", rd_flags, exp_q[0].fl);
                if (rd_ready) void'(exp_q.pop_front());
            end
        end
    end

    // One run: m=budget, te/t=trigger enable and the capture index whose PC matches (0=none),
    // p=post-trigger count, s=capture index carrying stop_req (0=none).
    task automatic run(input int m, input bit te, input int t, input int p, input int s,
                       input logic [31:0] base, input int mode, input bit drain, input bit pop_at_start);
        int n;
        int first;
        bit trg;
        bit trg_known;
        n = 1000;
        if (s != 0) n = s;
        if (m != 0 && m < n) n = m;
        trg = 1'b0;
        trg_known = 1'b1;
        if (te && t != 0) begin
            if (t < n) begin
                trg = 1'b1;
                if (t + p < n) n = t + p;
            end else if (t == n) begin
                trg_known = 1'b0;
            end
        end

        for (int k = 1; k <= n + 1; k++) begin
            s_pc[k]  = base + 32'(4 * (k - 1));
            s_alu[k] = $urandom;
            s_fl[k]  = 2'($urandom_range(0, 3));
        end

        max_cycles = CYCLE_W'(m);
        trig_en    = te;
        trig_pc    = (t != 0) ? base + 32'(4 * (t - 1)) : base + 32'd2;
        post_trig  = PT_W'(p);
        rd_ready   = pop_at_start;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        rd_ready   = 1'b0;

        for (int k = 1; k <= n + 1; k++) begin
            cpu_pc       = s_pc[k];
            cpu_aluout   = s_alu[k];
            cpu_memread  = s_fl[k][1];
            cpu_memwrite = s_fl[k][0];
            stop_req     = (k == s);
            @(negedge clk);
            check("pc_en", pc_en, k <= n);
            check("running", running, k <= n);
            check("cycle_count_run", cycle_count, CYCLE_W'(k - 1));
            tick();
        end
        stop_req = 1'b0;

        @(negedge clk);
        check("done", done, 1'b1);
        check("wrapped", wrapped, n > DEPTH);
        check("cycle_count_end", cycle_count, CYCLE_W'(n));
        if (trg_known) check("triggered", triggered, trg);

        if (drain) begin
            first = (n > DEPTH) ? n - DEPTH + 1 : 1;
            for (int k = first; k <= n; k++) exp_q.push_back('{pc: s_pc[k], alu: s_alu[k], fl: s_fl[k]});
            tick();
            mon_en = 1'b1;
            for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
                rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
                tick();
            end
            rd_ready = 1'b1;
            repeat (3) tick();
            @(negedge clk);
            check("drain_complete", 32'(exp_q.size()), 32'd0);
            check("rd_valid_after_drain", rd_valid, 1'b0);
            mon_en   = 1'b0;
            rd_ready = 1'b0;
            exp_q.delete();
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop_req = 1'b0; max_cycles = '0; trig_en = 1'b0;
        trig_pc = '0; post_trig = '0; cpu_pc = '0; cpu_aluout = '0; cpu_memread = 1'b0;
        cpu_memwrite = 1'b0; rd_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_pc_en", pc_en, 1'b0);
        check("rst_running", running, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_triggered", triggered, 1'b0);
        check("rst_wrapped", wrapped, 1'b0);
        check("rst_cycle_count", cycle_count, '0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_pc", rd_pc, '0);
        tick();
        rst = 1'b0;
        tick();

        run(5, 1'b0, 0, 0, 0, 32'h0000_1000, 0, 1'b1, 1'b0);   // budget of 5
        run(20, 1'b0, 0, 0, 0, 32'h0000_2000, 0, 1'b1, 1'b0);  // wrap: captures 5..20 survive
        run(0, 1'b1, 4, 3, 0, 32'h0000_0000, 0, 1'b1, 1'b0);   // trigger at 0x0C, post 3
        run(0, 1'b0, 0, 0, 3, 32'h0000_3000, 0, 1'b1, 1'b0);   // stop on 3rd cycle
        run(0, 1'b1, 2, 5, 4, 32'h0000_4000, 0, 1'b1, 1'b0);   // stop during POST
        run(0, 1'b1, 3, 0, 0, 32'h0000_5000, 0, 1'b1, 1'b0);   // trigger with post 0
        run(8, 1'b0, 0, 0, 0, 32'h0000_6000, 1, 1'b1, 1'b0);   // ready toggles 1,0,1

        for (int i = 0; i < 10; i++) begin
            int m, t, p, s;
            bit te;
            m  = $urandom_range(0, 25);
            s  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 25) : 0;
            te = 1'($urandom_range(0, 1));
            t  = $urandom_range(0, 20);
            p  = $urandom_range(0, 5);
            if (m == 0 && s == 0 && !(te && t != 0)) m = 10;
            run(m, te, t, p, s, $urandom & 32'hFFFF_FFFC, 2, 1'b1, 1'b0);
        end

        // Reset in the middle of an unbounded run.
        max_cycles = '0; trig_en = 1'b0; stop_req = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_pc_en", pc_en, 1'b0);
        check("midrst_running", running, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_cycle_count", cycle_count, '0);
        check("midrst_rd_valid", rd_valid, 1'b0);
        tick();

        // Leave entries pending, then start with a simultaneous pop request.
        run(3, 1'b0, 0, 0, 0, 32'h0000_7000, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("pending_rd_valid", rd_valid, 1'b1);
        tick();
        run(4, 1'b0, 0, 0, 0, 32'h0000_8000, 2, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
